// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM data-port arbiter.
// Holds the default SRAM address window, the constant returned for
// illegal accesses, the response tag carried through the in-order
// response FIFO, and the address legality check.
package sram_pkg;

  localparam logic [31:0] SRAM_BASE_ADDR_DEF = 32'h8000_0000;
  localparam logic [31:0] SRAM_END_ADDR_DEF  = 32'h8000_3000;
  localparam logic [31:0] DEAD_BEEF          = 32'hDEAD_BEEF;

  typedef enum logic {
    MST_M0 = 1'b0,
    MST_M1 = 1'b1
  } mst_id_t;

  typedef struct packed {
    mst_id_t id;
    logic    err;
  } resp_tag_t;

  // Address is inside [base, end_addr).
  function automatic logic addr_legal(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] end_addr);
    return (addr >= base) && (addr < end_addr);
  endfunction

endpackage

// File: rtl/sram_d_arbiter_if.sv
// OBI-style request/response bus.
//   req/addr/we/be/wdata : request channel, driven by the bus master
//   gnt                  : request accepted (combinational from the slave)
//   rvalid/rdata/err     : response channel, driven by the slave
// Modports:
//   master : the side issuing requests (no err; an SRAM never flags errors)
//   slave  : the side accepting requests and returning responses
interface sram_d_arbiter_if;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/obi_resp_fifo.sv
// In-order response-tracking FIFO of resp_tag_t.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset (flushes the FIFO)
//   push_i       : write data_i at the tail
//   pop_i        : drop the head entry
//   data_i       : entry to push
//   full_o       : no free slot
//   empty_o      : no valid entry
//   head_o       : oldest entry, read from registered storage
module obi_resp_fifo
  import sram_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  logic      pop_i,
  input  resp_tag_t data_i,
  output logic      full_o,
  output logic      empty_o,
  output resp_tag_t head_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one wrap bit to tell full from empty.
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  resp_tag_t   mem_q [DEPTH];
  resp_tag_t   mem_d [DEPTH];

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  // Push while full is legal only together with a pop: the slot written is
  // the head slot, whose old content is consumed this cycle from mem_q.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    mem_d = mem_q;
    if (push_i) begin
      mem_d[wr_q[AW-1:0]] = data_i;
      wr_d                = wr_q + 1'b1;
    end
    if (pop_i) begin
      rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/sram_d_arbiter.sv
// Two-master round-robin arbiter for the SRAM data port.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   m0           : core data bus (slave side of the OBI bus)
//   m1           : DMA/debug bus (slave side of the OBI bus)
//   s            : SRAM data port (master side of the OBI bus)
//   illegal_o    : one-cycle pulse after an out-of-window request is accepted
// Out-of-window requests never reach the SRAM; they are granted locally and
// answered with DEAD_BEEF and err=1. A response FIFO keeps the owner of every
// accepted transfer so responses are routed back in order.
module sram_d_arbiter
  import sram_pkg::*;
#(
  parameter logic [31:0] SRAM_BASE_ADDR = SRAM_BASE_ADDR_DEF,
  parameter logic [31:0] SRAM_END_ADDR  = SRAM_END_ADDR_DEF,
  parameter int unsigned RESP_DEPTH     = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  sram_d_arbiter_if.slave        m0,
  sram_d_arbiter_if.slave        m1,
  sram_d_arbiter_if.master       s,
  output logic                   illegal_o
);

  mst_id_t   rr_q, rr_d;
  logic      illegal_q, illegal_d;

  logic      fifo_full, fifo_empty, fifo_push, fifo_pop;
  resp_tag_t push_tag, head_tag;

  logic      legal0, legal1;
  logic      can_accept, req0, req1;
  logic      win_valid, win_legal, win_gnt;
  mst_id_t   win_id;
  logic [31:0] rsp_data;

  assign legal0 = addr_legal(m0.addr, SRAM_BASE_ADDR, SRAM_END_ADDR);
  assign legal1 = addr_legal(m1.addr, SRAM_BASE_ADDR, SRAM_END_ADDR);

  // Head pops when its response is available: error entries immediately,
  // SRAM entries when the SRAM returns rvalid.
  assign fifo_pop = !fifo_empty && (head_tag.err || s.rvalid);

  always_comb begin
    can_accept = !fifo_full || fifo_pop;
    req0       = m0.req && can_accept && !rst_i;
    req1       = m1.req && can_accept && !rst_i;

    win_valid = 1'b0;
    win_id    = MST_M0;
    if (req0 && req1) begin
      win_valid = 1'b1;
      win_id    = rr_q;
    end else if (req0) begin
      win_valid = 1'b1;
      win_id    = MST_M0;
    end else if (req1) begin
      win_valid = 1'b1;
      win_id    = MST_M1;
    end

    win_legal = (win_id == MST_M1) ? legal1 : legal0;

    s.req   = win_valid && win_legal;
    s.addr  = '0;
    s.we    = 1'b0;
    s.be    = '0;
    s.wdata = '0;
    if (s.req) begin
      if (win_id == MST_M1) begin
        s.addr  = m1.addr;
        s.we    = m1.we;
        s.be    = m1.be;
        s.wdata = m1.wdata;
      end else begin
        s.addr  = m0.addr;
        s.we    = m0.we;
        s.be    = m0.be;
        s.wdata = m0.wdata;
      end
    end

    // Illegal requests are accepted locally without waiting on the SRAM.
    win_gnt = win_valid && (!win_legal || s.gnt);
    m0.gnt  = win_gnt && (win_id == MST_M0);
    m1.gnt  = win_gnt && (win_id == MST_M1);

    fifo_push    = win_gnt;
    push_tag.id  = win_id;
    push_tag.err = !win_legal;

    rr_d      = rr_q;
    if (fifo_push) begin
      rr_d = (win_id == MST_M0) ? MST_M1 : MST_M0;
    end
    illegal_d = fifo_push && !win_legal;
  end

  always_comb begin
    rsp_data  = head_tag.err ? DEAD_BEEF : s.rdata;
    m0.rvalid = fifo_pop && (head_tag.id == MST_M0);
    m1.rvalid = fifo_pop && (head_tag.id == MST_M1);
    m0.rdata  = m0.rvalid ? rsp_data : '0;
    m1.rdata  = m1.rvalid ? rsp_data : '0;
    m0.err    = m0.rvalid && head_tag.err;
    m1.err    = m1.rvalid && head_tag.err;
  end

  obi_resp_fifo #(
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (push_tag),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head_tag)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q      <= MST_M0;
      illegal_q <= 1'b0;
    end else begin
      rr_q      <= rr_d;
      illegal_q <= illegal_d;
    end
  end

  assign illegal_o = illegal_q;

  // A stray SRAM rvalid with nothing outstanding is dropped; one arriving
  // while the head is a locally answered error indicates a protocol break.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(s.rvalid && !fifo_empty && head_tag.err))
        else $error("sram_d_arbiter: SRAM rvalid while head entry is a local error");
      assert (!(fifo_empty && (m0.rvalid || m1.rvalid)))
        else $error("sram_d_arbiter: master rvalid with no outstanding transfer");
    end
  end

endmodule

// File: tb/tb_sram_d_arbiter.sv
module tb_sram_d_arbiter;

  localparam int unsigned DEPTH = 2;

  logic clk;
  logic rst;
  logic illegal;

  sram_d_arbiter_if m0_if ();
  sram_d_arbiter_if m1_if ();
  sram_d_arbiter_if s_if ();

  sram_d_arbiter #(
    .SRAM_BASE_ADDR (32'h8000_0000),
    .SRAM_END_ADDR  (32'h8000_3000),
    .RESP_DEPTH     (DEPTH)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .m0        (m0_if),
    .m1        (m1_if),
    .s         (s_if),
    .illegal_o (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Reference model: queue of outstanding responses in acceptance order,
  // round-robin priority, and the pending illegal pulse.
  typedef struct {
    int id;
    bit err;
    bit we;
  } exp_rsp_t;

  exp_rsp_t q[$];
  int       prio;
  bit       ill_exp;
  int       errors;
  int       checks;

  function automatic bit is_legal(input logic [31:0] a);
    return (a >= 32'h8000_0000) && (a < 32'h8000_3000);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int m, input bit req, input logic [31:0] addr, input bit we);
    logic [3:0]  be;
    logic [31:0] wd;
    be = 4'($urandom);
    wd = $urandom;
    if (m == 0) begin
      m0_if.req = req; m0_if.addr = addr; m0_if.we = we; m0_if.be = be; m0_if.wdata = wd;
    end else begin
      m1_if.req = req; m1_if.addr = addr; m1_if.we = we; m1_if.be = be; m1_if.wdata = wd;
    end
  endtask

  task automatic idle();
    m0_if.req = 1'b0;
    m1_if.req = 1'b0;
  endtask

  // One clock cycle: check outputs at the falling edge against the model,
  // advance the model at the rising edge, then play the SRAM for the next cycle.
  task automatic cycle();
    logic        eg0, eg1, esreq, erv0, erv1, eerr0, eerr1, ewe, g, skip0, skip1;
    logic [31:0] erd0, erd1, eaddr, ewdata, a, rd;
    logic [3:0]  ebe;
    bit          pop, acc, r0, r1, wlegal, acc_now, s_next;
    int          win;
    @(negedge clk);
    {eg0, eg1, esreq, erv0, erv1, eerr0, eerr1, ewe, skip0, skip1} = '0;
    erd0 = '0; erd1 = '0; eaddr = '0; ewdata = '0; ebe = '0;
    pop = 0; wlegal = 0; win = -1;
    if (!rst) begin
      if (q.size() > 0 && (q[0].err || s_if.rvalid)) begin
        pop = 1;
        rd  = q[0].err ? 32'hDEAD_BEEF : s_if.rdata;
        if (q[0].id == 0) begin
          erv0 = 1; erd0 = rd; eerr0 = q[0].err; skip0 = q[0].we && !q[0].err;
        end else begin
          erv1 = 1; erd1 = rd; eerr1 = q[0].err; skip1 = q[0].we && !q[0].err;
        end
      end
      acc = (q.size() < DEPTH) || pop;
      r0  = m0_if.req && acc;
      r1  = m1_if.req && acc;
      if (r0 && r1) win = prio;
      else if (r0)  win = 0;
      else if (r1)  win = 1;
      if (win >= 0) begin
        a      = (win == 1) ? m1_if.addr : m0_if.addr;
        wlegal = is_legal(a);
        if (wlegal) begin
          esreq  = 1;
          eaddr  = a;
          ewe    = (win == 1) ? m1_if.we : m0_if.we;
          ebe    = (win == 1) ? m1_if.be : m0_if.be;
          ewdata = (win == 1) ? m1_if.wdata : m0_if.wdata;
          g      = s_if.gnt;
        end else begin
          g = 1;
        end
        if (win == 0) eg0 = g; else eg1 = g;
      end
    end
    chk("m0_gnt", 32'(m0_if.gnt), 32'(eg0));
    chk("m1_gnt", 32'(m1_if.gnt), 32'(eg1));
    chk("s_req", 32'(s_if.req), 32'(esreq));
    chk("s_addr", s_if.addr, eaddr);
    chk("s_we", 32'(s_if.we), 32'(ewe));
    chk("s_be", 32'(s_if.be), 32'(ebe));
    chk("s_wdata", s_if.wdata, ewdata);
    chk("m0_rvalid", 32'(m0_if.rvalid), 32'(erv0));
    chk("m1_rvalid", 32'(m1_if.rvalid), 32'(erv1));
    chk("m0_err", 32'(m0_if.err), 32'(eerr0));
    chk("m1_err", 32'(m1_if.err), 32'(eerr1));
    if (!skip0) chk("m0_rdata", m0_if.rdata, erd0);
    if (!skip1) chk("m1_rdata", m1_if.rdata, erd1);
    chk("illegal", 32'(illegal), rst ? 32'h0 : 32'(ill_exp));
    @(posedge clk);
    s_next = 0;
    if (rst) begin
      q.delete();
      prio    = 0;
      ill_exp = 0;
    end else begin
      if (pop) void'(q.pop_front());
      acc_now = (win >= 0) && (eg0 || eg1);
      ill_exp = acc_now && !wlegal;
      s_next  = acc_now && wlegal;
      if (acc_now) begin
        q.push_back('{id: win, err: !wlegal, we: ((win == 1) ? m1_if.we : m0_if.we)});
        prio = 1 - win;
      end
    end
    #1;
    s_if.rvalid = s_next;
    s_if.rdata  = s_next ? $urandom : 32'h0;
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] off;
    case ($urandom_range(0, 6))
      0:       return 32'h8000_2FFC;
      1:       return 32'h8000_3000;
      2:       return 32'h7FFF_FFFC;
      3:       return $urandom;
      default: begin
        off = 32'($urandom_range(0, 3071)) << 2;
        return 32'h8000_0000 + off;
      end
    endcase
  endfunction

  initial begin
    errors = 0; checks = 0; prio = 0; ill_exp = 0;
    rst = 1'b1;
    drv(0, 0, 32'h0, 0);
    drv(1, 0, 32'h0, 0);
    s_if.gnt = 1'b1; s_if.rvalid = 1'b0; s_if.rdata = 32'h0; s_if.err = 1'b0;

    // Reset state, including requests held during reset.
    cycle();
    drv(0, 1, 32'h8000_0010, 0);
    drv(1, 1, 32'h0000_0100, 0);
    cycle();
    idle();
    rst = 1'b0;
    cycle();

    // Single m0 read; SRAM returns 0x1234_5678.
    drv(0, 1, 32'h8000_0010, 0);
    cycle();
    idle();
    s_if.rdata = 32'h1234_5678;
    cycle();
    cycle();

    // Both masters request every cycle: grants alternate.
    for (int i = 0; i < 8; i++) begin
      drv(0, 1, 32'h8000_0100 + 32'(i) * 4, i[0]);
      drv(1, 1, 32'h8000_1000 + 32'(i) * 4, 0);
      cycle();
    end
    idle();
    cycle();

    // m1 illegal read answered locally.
    drv(1, 1, 32'h0000_0100, 0);
    cycle();
    idle();
    cycle();
    cycle();

    // Window boundaries.
    drv(0, 1, 32'h8000_2FFC, 0);
    cycle();
    drv(0, 1, 32'h8000_3000, 0);
    cycle();
    drv(0, 1, 32'h7FFF_FFFC, 1);
    cycle();
    idle();
    cycle();
    cycle();

    // SRAM withholds gnt for three cycles.
    s_if.gnt = 1'b0;
    drv(0, 1, 32'h8000_0200, 0);
    cycle();
    cycle();
    cycle();
    s_if.gnt = 1'b1;
    cycle();
    idle();
    cycle();
    cycle();

    // Reset while a response is pending, then a stale SRAM rvalid.
    drv(1, 1, 32'h8000_0300, 0);
    cycle();
    idle();
    drv(1, 1, 32'h8000_0300, 0);
    cycle();
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    s_if.rvalid = 1'b1;
    s_if.rdata  = 32'hCAFE_F00D;
    drv(0, 1, 32'h8000_0400, 0);
    drv(1, 1, 32'h8000_0500, 0);
    cycle();
    idle();
    cycle();

    // Randomised traffic.
    for (int i = 0; i < 200; i++) begin
      drv(0, ($urandom_range(0, 3) != 0), pick_addr(), 1'($urandom));
      drv(1, ($urandom_range(0, 2) != 0), pick_addr(), 1'($urandom));
      s_if.gnt = ($urandom_range(0, 3) != 0);
      cycle();
    end
    idle();
    s_if.gnt = 1'b1;
    cycle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
